// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one
// transaction in flight; data has priority, a starvation counter forces fetch through.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state,
  output logic [3:0]  dbg_starve_cnt
);

  // Handshakes: if_req/d_req are levels held until the matching gnt is high in the
  // same cycle; mem_req and all mem_* stay stable until a cycle with mem_ack high.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    ERR_IF  = 2'd3
  } state_e;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        kill_q, kill_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic fetch_elig;
  logic fetch_win;
  logic data_win;
  logic kill_now;
  logic err_resp;
  logic unused_d_addr_lsb;

  assign unused_d_addr_lsb = ^d_addr[1:0];

  always_comb begin
    fetch_elig = if_req & ~if_flush;
    fetch_win  = (state_q == IDLE) & fetch_elig &
                 (~d_req | (starve_cnt_q == STARVE_MAX));
    data_win   = (state_q == IDLE) & d_req & ~fetch_win;
    // A flush in the very cycle the fetch finishes still suppresses its response.
    kill_now   = kill_q | if_flush;
    err_resp   = (state_q == ERR_IF) & ~kill_now;
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    kill_d       = kill_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rvalid_d   = 1'b0;
    d_rdata_d    = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (fetch_win) begin
          starve_cnt_d = 4'd0;
          if (if_addr[1:0] != 2'b00) begin
            state_d = ERR_IF;
          end else begin
            state_d     = BUSY_IF;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_be_d    = 4'hF;
            mem_addr_d  = {if_addr[31:2], 2'b00};
            mem_wdata_d = 32'd0;
          end
        end else if (data_win) begin
          if (fetch_elig && (starve_cnt_q < STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_be_d    = d_be;
          mem_addr_d  = {d_addr[31:2], 2'b00};
          mem_wdata_d = d_wdata;
        end
      end
      BUSY_IF: begin
        kill_d = kill_now;
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          kill_d    = 1'b0;
          if (!kill_now) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          d_rvalid_d = 1'b1;
          d_rdata_d  = mem_we_q ? 32'd0 : mem_rdata;
        end
      end
      ERR_IF: begin
        state_d = IDLE;
        kill_d  = 1'b0;
        if (!kill_now) begin
          if_rdata_d = 32'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      kill_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'd0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= 32'd0;
      d_rvalid_q   <= 1'b0;
      d_rdata_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      kill_q       <= kill_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      d_rvalid_q   <= d_rvalid_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // The misaligned-fetch error is answered straight from ERR_IF so a flush in that
  // cycle can still cancel it; if_rdata reads zero for the error response.
  assign if_gnt         = fetch_win;
  assign d_gnt          = data_win;
  assign if_rvalid      = if_rvalid_q | err_resp;
  assign if_err         = err_resp;
  assign if_rdata       = (state_q == ERR_IF) ? 32'd0 : if_rdata_q;
  assign d_rvalid       = d_rvalid_q;
  assign d_rdata        = d_rdata_q;
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_be         = mem_be_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_cnt_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port unified memory between the instruction-fetch stage and the load/store (data) stage. One transaction is outstanding at a time. Data requests have fixed priority, with a starvation guard that forces fetch through. An in-flight fetch can be killed by a pipeline flush; its response is then discarded.

Parameters:
STARVE_LIMIT, 4, consecutive cycles a pending fetch may lose arbitration before it is forced to win (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
if_req  in  1  fetch request, level; held until if_gnt
if_addr  in  32  fetch byte address
if_flush  in  1  kill pending/in-flight fetch
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  fetch response pulse
if_rdata  out  32  fetch data
if_err  out  1  misaligned fetch, valid with if_rvalid
d_req  in  1  data request, level; held until d_gnt
d_we  in  1  1=store
d_be  in  4  byte enables (stores)
d_addr  in  32  data byte address
d_wdata  in  32  store data
d_gnt  out  1  data accepted this cycle
d_rvalid  out  1  data response pulse (loads and stores)
d_rdata  out  32  load data
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  write
mem_be  out  4  byte enables
mem_addr  out  32  word address bits [31:2], zero in [1:0]
mem_wdata  out  32  write data
mem_ack  in  1  memory completes; mem_rdata valid same cycle
mem_rdata  in  32  read data

Behaviour:
- Reset: state IDLE. All outputs 0. starve_cnt=0, kill=0. Reset mid-transaction abandons it; mem_req drops immediately (async). A mem_ack arriving in IDLE is ignored.
- States: IDLE, BUSY_IF, BUSY_D, ERR_IF.
- IDLE arbitration (combinational gnt, one winner):
  - Fetch is eligible when if_req & !if_flush.
  - Fetch wins if eligible and (!d_req or starve_cnt==STARVE_LIMIT). Otherwise data wins if d_req.
- Grant actions:
  - Fetch grant with if_addr[1:0]!=0 goes to ERR_IF with no memory access.
  - Other grants register mem_req=1, mem_we, mem_be, mem_addr, mem_wdata and go to BUSY_x.
  - Fetch: mem_we=0, mem_be=4'hF.
  - Data load: mem_be=d_be, mem_we=0.
  - Data addresses are not alignment-checked.
- mem_* hold stable while mem_req=1.
- BUSY_x: wait for mem_ack. On ack: mem_req<=0, state<=IDLE, capture mem_rdata. Next cycle pulse x_rvalid for 1 cycle with x_rdata.
  - d_rdata is undefined-but-0 for stores.
  - Earliest next grant is the cycle after ack (same cycle as rvalid).
  - Minimum issue-to-response latency is 2 cycles: gnt at T, mem_req at T+1, ack at T+1, rvalid at T+2.
- ERR_IF: next cycle if_rvalid=1, if_err=1, if_rdata=0, then IDLE.
- Flush:
  - if_flush in BUSY_IF or ERR_IF sets kill. This includes the ack cycle itself.
  - When kill is set, that transaction's if_rvalid/if_err is suppressed. kill clears on return to IDLE.
  - The memory transaction still completes; it is not aborted.
  - Flush has no effect on data transactions.
- starve_cnt:
  - In IDLE, increments (saturating at STARVE_LIMIT) when fetch is eligible but data is granted.
  - Clears on any fetch grant.
  - Holds in BUSY states.
- x_rdata holds its value between pulses. x_gnt and x_rvalid are never 1 for both requesters in the same cycle.

Test Plan:
- Single fetch, if_addr=0x100, mem_ack 1 cycle after mem_req -> if_gnt at T, mem_addr=0x100 at T+1, if_rvalid=1 with if_rdata=mem_rdata (0xDEADBEEF) at T+2.
- d_req and if_req held continuously, stores to 0x200, STARVE_LIMIT=4 -> 4 data grants, then 1 fetch grant, starve_cnt back to 0, pattern repeats.
- Fetch in BUSY_IF, if_flush pulsed on the ack cycle, then a new fetch 0x40 -> no response for the flushed fetch, 0x40 response delivered normally, kill cleared.
- Fetch with if_addr=0x102 -> if_gnt, mem_req stays 0, next cycle if_rvalid=1, if_err=1, if_rdata=0.
- Store d_be=4'b0011, wdata=0x1234ABCD, addr 0x303, mem_ack delayed 5 cycles -> mem_addr=0x300, mem_* stable for 5 cycles, d_rvalid one cycle after ack.
- rst asserted while BUSY_D, mem_ack arrives after release -> mem_req=0 immediately, no d_rvalid, arbiter accepts a new request the cycle after reset release.
